// File: rtl/freq_meas_master_if.sv
// Wishbone classic bus between the frequency-measurement master and the ALU slave.
interface freq_meas_master_if;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic        we_o;
    logic [7:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic        lock_o;
    logic        ack_i;
    logic        err_i;
    logic        rty_i;

    modport master (
        output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o,
        input  ack_i, err_i, rty_i
    );

    modport slave (
        input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o, lock_o,
        output ack_i, err_i, rty_i
    );
endinterface

// File: rtl/freq_meas_master.sv
// Reciprocal frequency counter; sends count_x then count_ref to the ALU in one locked Wishbone cycle.
// Optional macro FREQ_MEAS_RETRY_EN: rty_i re-issues a beat (max 3 times) instead of failing.
module freq_meas_master #(
    parameter int unsigned GATE_CYCLES    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [31:0] OPA_ADDR       = 32'h0000_0000,
    parameter logic [31:0] OPB_ADDR       = 32'h0000_0004
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               sig_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               error_o,
    freq_meas_master_if.master wb
);
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
    localparam logic [31:0] GATE_K  = 32'(GATE_CYCLES);
    localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    typedef enum logic [3:0] {
        IDLE, ARM, MEASURE, CLOSE, WR_A, GAP, WR_B, DONE, FAIL, RTY_A, RTY_B
    } state_t;

    state_t      state_q, state_d;
    logic        sig_p0, sig_p1, sig_p2;
    logic        edge_evt;
    logic [31:0] x_cnt, ref_cnt, to_cnt;
    logic [31:0] count_ref, adr_q, dat_q;
    logic [31:0] k, x_next;
    logic        error_q;
    logic        rty_fail;
    logic        bus_cyc, bus_stb;
`ifdef FREQ_MEAS_RETRY_EN
    logic [1:0]  rty_cnt;
`endif

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    // k is the cycle index relative to the opening edge for the current cycle
    assign edge_evt = sig_p1 & ~sig_p2;
    assign k        = sat_inc(ref_cnt);
    assign x_next   = sat_inc(x_cnt);

`ifdef FREQ_MEAS_RETRY_EN
    assign rty_fail = (rty_cnt == 2'd3);
`else
    assign rty_fail = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = ARM;
            ARM: begin
                if (edge_evt)               state_d = MEASURE;
                else if (to_cnt >= TO_LAST) state_d = FAIL;
            end
            MEASURE: begin
                if (edge_evt && (k >= GATE_K)) state_d = WR_A;
                else if (k >= GATE_K)          state_d = CLOSE;
            end
            CLOSE: begin
                if (edge_evt)               state_d = WR_A;
                else if (to_cnt >= TO_LAST) state_d = FAIL;
            end
            WR_A: begin
                if (wb.err_i)      state_d = FAIL;
                else if (wb.rty_i) state_d = rty_fail ? FAIL : RTY_A;
                else if (wb.ack_i) state_d = GAP;
            end
            RTY_A:   state_d = WR_A;
            GAP:     state_d = WR_B;
            WR_B: begin
                if (wb.err_i)      state_d = FAIL;
                else if (wb.rty_i) state_d = rty_fail ? FAIL : RTY_B;
                else if (wb.ack_i) state_d = DONE;
            end
            RTY_B:   state_d = WR_B;
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            sig_p0    <= 1'b0;
            sig_p1    <= 1'b0;
            sig_p2    <= 1'b0;
            x_cnt     <= '0;
            ref_cnt   <= '0;
            to_cnt    <= '0;
            count_ref <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            error_q   <= 1'b0;
`ifdef FREQ_MEAS_RETRY_EN
            rty_cnt   <= '0;
`endif
        end else begin
            // synchronizer stages, then edge history
            sig_p0  <= sig_i;
            sig_p1  <= sig_p0;
            sig_p2  <= sig_p1;
            state_q <= state_d;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        error_q <= 1'b0;
                        x_cnt   <= '0;
                        ref_cnt <= '0;
                        to_cnt  <= '0;
                    end
                end
                ARM: begin
                    to_cnt <= sat_inc(to_cnt);
                    if (edge_evt) begin
                        x_cnt   <= '0;
                        ref_cnt <= '0;
                    end
                end
                MEASURE, CLOSE: begin
                    ref_cnt <= k;
                    if (edge_evt) x_cnt <= x_next;
                    if ((k == CNT_MAX) || (edge_evt && (x_next == CNT_MAX))) error_q <= 1'b1;
                    to_cnt <= (state_d == CLOSE && state_q == MEASURE) ? 32'd0 : sat_inc(to_cnt);
                    if (state_d == WR_A) begin
                        count_ref <= k;
                        adr_q     <= OPA_ADDR;
                        dat_q     <= x_next;
                    end
                end
                GAP: begin
                    adr_q <= OPB_ADDR;
                    dat_q <= count_ref;
                end
                default: ;
            endcase

            if (state_d == FAIL) error_q <= 1'b1;

`ifdef FREQ_MEAS_RETRY_EN
            if (state_d == RTY_A || state_d == RTY_B)        rty_cnt <= rty_cnt + 2'd1;
            else if (state_d == GAP || state_q == MEASURE ||
                     state_q == CLOSE)                       rty_cnt <= '0;
`endif
        end
    end

    // bus outputs decode straight from the state register so reset drops them at once
    assign bus_stb   = (state_q == WR_A) || (state_q == WR_B);
    assign bus_cyc   = bus_stb || (state_q == GAP) || (state_q == RTY_A) || (state_q == RTY_B);

    assign wb.stb_o  = bus_stb;
    assign wb.cyc_o  = bus_cyc;
    assign wb.lock_o = bus_cyc;
    assign wb.we_o   = bus_cyc;
    assign wb.sel_o  = bus_stb ? 8'hFF : 8'h00;
    assign wb.adr_o  = adr_q;
    assign wb.dat_o  = dat_q;

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign error_o   = error_q;
endmodule

// File: tb/tb_freq_meas_master.sv
// Scoreboard bench for freq_meas_master: random edge trains, randomized slave responses, reference count model.
module tb_freq_meas_master;
    localparam int          GATE = 100;
    localparam int          TOUT = 50;
    localparam logic [31:0] OPA  = 32'h0000_0000;
    localparam logic [31:0] OPB  = 32'h0000_0004;

    typedef struct { int code; int dly; } rsp_t;   // code: 0 ack, 1 err, 2 rty, 3 ack+err
    typedef struct { logic [31:0] adr; logic [31:0] dat; } beat_t;

    logic clk_i, rst_i, sig_i, start_i;
    logic busy_o, done_o, error_o;

    freq_meas_master_if bus();

    freq_meas_master #(.GATE_CYCLES(GATE), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sig_i   (sig_i),
        .start_i (start_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .error_o (error_o),
        .wb      (bus)
    );

    int    checks = 0;
    int    failures = 0;
    rsp_t  plan[$];
    beat_t exp_beats[$];
    int    exp_evt[$];     // 0 = done, 1 = fail
    int    iv[$];          // intervals between consecutive sig_i rising edges
    bit    cyc_seen;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: the closing edge is the first whose distance from the opening edge reaches GATE.
    function automatic void model(output logic [31:0] cx, output logic [31:0] cr);
        int  cum = 0;
        bit  found = 0;
        cx = 0;
        cr = 0;
        for (int i = 0; i < iv.size(); i++) begin
            cum += iv[i];
            if (!found && cum >= GATE) begin
                found = 1;
                cx = 32'(i + 1);
                cr = 32'(cum);
            end
        end
    endfunction

    task automatic gen_iv(input int fixed, input bit extras);
        int cum = 0;
        int d;
        iv.delete();
        while (cum < GATE) begin
            d = (fixed != 0) ? fixed : int'($urandom_range(2, 40));
            iv.push_back(d);
            cum += d;
        end
        if (extras) begin
            iv.push_back(int'($urandom_range(2, 40)));
            iv.push_back(int'($urandom_range(2, 40)));
        end
    endtask

    task automatic drive_sig(input int lead, input bit poke);
        repeat (lead) begin @(posedge clk_i); #1; end
        sig_i = 1'b1;
        for (int i = 0; i < iv.size(); i++) begin
            automatic int h = iv[i] / 2;
            if (poke && i == 1) start_i = 1'b1;
            for (int c = 0; c < iv[i]; c++) begin
                @(posedge clk_i); #1;
                start_i = 1'b0;
                if (c == h - 1) sig_i = 1'b0;
            end
            sig_i = 1'b1;
        end
        repeat (2) begin @(posedge clk_i); #1; end
        sig_i = 1'b0;
    endtask

    function automatic rsp_t mk(input int code);
        rsp_t r;
        r.code = code;
        r.dly  = int'($urandom_range(0, 2));
        return r;
    endfunction

    function automatic void push_beat(input logic [31:0] adr, input logic [31:0] dat);
        beat_t b;
        b.adr = adr;
        b.dat = dat;
        exp_beats.push_back(b);
    endfunction

    task automatic pulse_start();
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        chk("start_clears_error", 32'(error_o), 32'd0);
        chk("busy_after_start", 32'(busy_o), 32'd1);
    endtask

    task automatic wait_idle_and_drain(input logic exp_err);
        int n = 0;
        while (busy_o && n < 600) begin @(posedge clk_i); #1; n++; end
        chk("returned_idle", 32'(busy_o), 32'd0);
        chk("beats_left", 32'(exp_beats.size()), 32'd0);
        chk("events_left", 32'(exp_evt.size()), 32'd0);
        chk("plan_left", 32'(plan.size()), 32'd0);
        chk("sticky_error", 32'(error_o), 32'(exp_err));
        exp_beats.delete();
        exp_evt.delete();
        plan.delete();
        repeat (3) begin @(posedge clk_i); #1; end
    endtask

    // kind: 0 normal, 1 err on WR_B, 2 two retries on WR_A, 3 four retries on WR_A, 4 ack+err on WR_A
    task automatic run_meas(input int kind, input int fixed, input bit poke);
        logic [31:0] cx, cr;
        logic        exp_err;
        gen_iv(fixed, 1'b1);
        model(cx, cr);
        exp_err = 1'b1;
        case (kind)
            0: begin
                plan.push_back(mk(0)); plan.push_back(mk(0));
                push_beat(OPA, cx); push_beat(OPB, cr);
                exp_evt.push_back(0); exp_err = 1'b0;
            end
            1: begin
                plan.push_back(mk(0)); plan.push_back(mk(1));
                push_beat(OPA, cx); push_beat(OPB, cr);
                exp_evt.push_back(1);
            end
            2: begin
`ifdef FREQ_MEAS_RETRY_EN
                plan.push_back(mk(2)); plan.push_back(mk(2));
                plan.push_back(mk(0)); plan.push_back(mk(0));
                push_beat(OPA, cx); push_beat(OPA, cx); push_beat(OPA, cx); push_beat(OPB, cr);
                exp_evt.push_back(0); exp_err = 1'b0;
`else
                plan.push_back(mk(2));
                push_beat(OPA, cx);
                exp_evt.push_back(1);
`endif
            end
            3: begin
`ifdef FREQ_MEAS_RETRY_EN
                for (int i = 0; i < 4; i++) begin plan.push_back(mk(2)); push_beat(OPA, cx); end
`else
                plan.push_back(mk(2));
                push_beat(OPA, cx);
`endif
                exp_evt.push_back(1);
            end
            default: begin
                plan.push_back(mk(3));
                push_beat(OPA, cx);
                exp_evt.push_back(1);
            end
        endcase
        pulse_start();
        drive_sig(int'($urandom_range(1, 5)), poke);
        wait_idle_and_drain(exp_err);
    endtask

    // Wishbone slave: answers each strobe from the response plan (default: immediate ack).
    initial begin
        rsp_t cur;
        bit   have;
        bit   rsp_now;
        int   wait_cnt;
        have = 0; rsp_now = 0; wait_cnt = 0;
        cur.code = 0; cur.dly = 0;
        bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            bus.ack_i = 1'b0; bus.err_i = 1'b0; bus.rty_i = 1'b0;
            if (!rst_i) begin
                have = 0; rsp_now = 0;
            end else if (bus.stb_o && !rsp_now) begin
                if (!have) begin
                    if (plan.size() > 0) cur = plan.pop_front();
                    else begin cur.code = 0; cur.dly = 0; end
                    have = 1;
                    wait_cnt = cur.dly;
                end
                if (wait_cnt == 0) begin
                    bus.ack_i = (cur.code == 0 || cur.code == 3);
                    bus.err_i = (cur.code == 1 || cur.code == 3);
                    bus.rty_i = (cur.code == 2);
                    have = 0;
                    rsp_now = 1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                rsp_now = 0;
            end
        end
    end

    // Monitor: pops expected beats on each answered strobe and expected outcomes on done/error.
    initial begin
        bit    err_prev;
        beat_t b;
        int    ev;
        err_prev = 0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (bus.cyc_o) cyc_seen = 1;
                if (bus.stb_o && (bus.ack_i || bus.err_i || bus.rty_i)) begin
                    if (exp_beats.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_beat adr=%0h dat=%0h required=none", bus.adr_o, bus.dat_o);
                    end else begin
                        b = exp_beats.pop_front();
                        chk("beat_adr", bus.adr_o, b.adr);
                        chk("beat_dat", bus.dat_o, b.dat);
                        chk("beat_sel", 32'(bus.sel_o), 32'h0000_00FF);
                        chk("beat_lock_we_cyc", 32'({bus.lock_o, bus.we_o, bus.cyc_o}), 32'd7);
                    end
                end
                if (done_o || (error_o && !err_prev)) begin
                    if (exp_evt.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_outcome done=%0b error=%0b required=none", done_o, error_o);
                    end else begin
                        ev = exp_evt.pop_front();
                        chk("outcome_err_done", 32'({error_o, done_o}), (ev == 0) ? 32'd1 : 32'd2);
                        chk("outcome_bus_idle", 32'({bus.cyc_o, bus.stb_o, bus.lock_o}), 32'd0);
                    end
                end
                err_prev = error_o;
            end else begin
                err_prev = 0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i = 1'b0; sig_i = 1'b0; start_i = 1'b0; cyc_seen = 0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_busy_done_err", 32'({busy_o, done_o, error_o}), 32'd0);
        chk("rst_cyc_stb_lock_we", 32'({bus.cyc_o, bus.stb_o, bus.lock_o, bus.we_o}), 32'd0);
        chk("rst_sel", 32'(bus.sel_o), 32'd0);
        chk("rst_adr", bus.adr_o, 32'd0);
        chk("rst_dat", bus.dat_o, 32'd0);
        rst_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end

        run_meas(0, 10, 1'b0);   // expect 10 / 100
        run_meas(0, 7, 1'b0);    // expect 15 / 105

        // sig_i held low: timeout in ARM, no bus activity
        cyc_seen = 0;
        exp_evt.push_back(1);
        @(posedge clk_i); #1;
        start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        n = 0;
        while (!error_o && n < 200) begin @(posedge clk_i); #1; n++; end
        chk("timeout_latency_in_window", 32'(n >= TOUT - 2 && n <= TOUT + 3), 32'd1);
        chk("timeout_no_cyc", 32'(cyc_seen), 32'd0);
        wait_idle_and_drain(1'b1);

        run_meas(1, 0, 1'b0);    // err on WR_B
        run_meas(0, 0, 1'b0);    // start clears the sticky error
        run_meas(2, 0, 1'b0);    // two retries on WR_A
        run_meas(3, 0, 1'b0);    // retry limit exceeded
        run_meas(4, 0, 1'b0);    // ack and err together: err wins
        run_meas(0, 0, 1'b1);    // start_i during MEASURE is ignored

        // reset asserted while WR_A is waiting for a slow ack
        gen_iv(10, 1'b0);
        plan.push_back('{code: 0, dly: 8});
        pulse_start();
        drive_sig(2, 1'b0);
        n = 0;
        while (!bus.stb_o && n < 300) begin @(posedge clk_i); #1; n++; end
        chk("rst_mid_stb_seen", 32'(bus.stb_o), 32'd1);
        #3;
        rst_i = 1'b0;
        #1;
        chk("rst_mid_cyc_stb_busy", 32'({bus.cyc_o, bus.stb_o, busy_o}), 32'd0);
        chk("rst_mid_lock", 32'(bus.lock_o), 32'd0);
        plan.delete();
        exp_beats.delete();
        exp_evt.delete();
        repeat (2) begin @(posedge clk_i); #1; end
        rst_i = 1'b1;
        repeat (2) begin @(posedge clk_i); #1; end
        run_meas(0, 0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            automatic int sel = int'($urandom_range(0, 5));
            automatic int kind = (sel == 5) ? 4 : ((sel == 4) ? 2 : ((sel == 3) ? 1 : 0));
            run_meas(kind, 0, ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
